// File: rtl/ntr_command_rx_pkg.sv
// Shared definitions for the NTR command receiver.
//   NTR_CMD_BYTES_MAX : widest command the bus can carry, in bytes
//   ntr_state_e       : receiver FSM states
//   ntr_align_cmd     : moves a right-justified command so its first byte sits in [63:56]
package ntr_command_rx_pkg;

    localparam int unsigned NTR_CMD_BYTES_MAX = 8;
    localparam int unsigned NTR_CMD_W         = 8 * NTR_CMD_BYTES_MAX;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StResp = 2'd2
    } ntr_state_e;

    // The shadow register accumulates bytes from the bottom; a short command must be
    // shifted up so byte 0 lands in the top byte and the unused low bits read 0.
    function automatic logic [NTR_CMD_W-1:0] ntr_align_cmd(input logic [NTR_CMD_W-1:0] word,
                                                           input int unsigned nbytes);
        return word << (8 * (NTR_CMD_BYTES_MAX - nbytes));
    endfunction

endpackage

// File: rtl/ntr_command_rx_up_counter.sv
// Byte index counter for the NTR command receiver.
//   clk    : clock
//   clr    : active-high synchronous clear (covers reset too)
//   inc    : advance by one; wraps to 0 after MAX-1
//   at_max : count currently equals MAX-1 (next strobe is the last byte)
module ntr_command_rx_up_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MAX   = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    logic [WIDTH-1:0] count_q;

    assign at_max = (count_q == WIDTH'(MAX - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= at_max ? '0 : count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ntr_command_rx.sv
// NTR cartridge bus command receiver.
// Captures the CMD_BYTES-byte command at the start of each chip-select window and
// hands it to the decoder as one 64-bit word with a valid/ack handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   cs         : chip select (window open)
//   en, data_in: byte strobe and bus byte
//   cmd        : captured command, first byte in [63:56]
//   cmd_valid  : cmd holds an unacknowledged command; cmd_ack takes it
//   busy       : FSM is in CMD or RESP
//   aborted    : one-cycle pulse when cs drops mid-command
//   overrun    : sticky, a completed command was dropped because cmd_valid was high
import ntr_command_rx_pkg::*;

module ntr_command_rx #(
    parameter int unsigned CMD_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [63:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic        busy,
    output logic        aborted,
    output logic        overrun
);

    ntr_state_e  state_q, state_d;
    logic [63:0] shadow_q, shadow_next;
    logic [63:0] cmd_q;
    logic        cmd_valid_q, aborted_q, overrun_q;

    logic        at_last;
    logic        cnt_inc, cnt_clr, exit_cmd;
    logic        shift_en, commit, abort_d;

    assign shadow_next = {shadow_q[55:0], data_in};

    always_comb begin
        state_d  = state_q;
        cnt_inc  = 1'b0;
        exit_cmd = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs) begin
                    state_d = StCmd;
                    cnt_inc = en; // byte 0 may arrive on the opening cycle
                end
            end
            StCmd: begin
                // cs loss wins over a strobe in the same cycle
                if (!cs) begin
                    state_d  = StIdle;
                    exit_cmd = 1'b1;
                    abort_d  = 1'b1;
                end else if (en) begin
                    shift_en = 1'b1;
                    if (at_last) begin
                        state_d  = StResp;
                        exit_cmd = 1'b1;
                        commit   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            StResp: begin
                if (!cs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cnt_clr = !rst_n || exit_cmd;

    ntr_command_rx_up_counter #(
        .WIDTH(3),
        .MAX  (CMD_BYTES)
    ) u_byte_idx (
        .clk   (clk),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .at_max(at_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle) begin
                shadow_q <= (cs && en) ? {56'b0, data_in} : '0;
            end else if (shift_en) begin
                shadow_q <= shadow_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            aborted_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            aborted_q <= abort_d;
            if (commit) begin
                // An ack in the commit cycle frees the slot for the new command.
                if (!cmd_valid_q || cmd_ack) begin
                    cmd_q       <= ntr_align_cmd(shadow_next, CMD_BYTES);
                    cmd_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (cmd_ack) begin
                cmd_valid_q <= 1'b0;
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign aborted   = aborted_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ntr_command_rx.sv
module tb_ntr_command_rx;

    localparam int unsigned CMD_BYTES = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        cmd_ack = 1'b0;
    logic [63:0] cmd;
    logic        cmd_valid, busy, aborted, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a window is open/closed, the command is either still being
    // collected (byte queue) or done; the consumer side is a one-deep mailbox.
    bit          m_open, m_done, m_valid, m_over, m_abort;
    logic [63:0] m_cmd;
    logic [7:0]  m_q[$];

    ntr_command_rx #(
        .CMD_BYTES(CMD_BYTES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .en       (en),
        .data_in  (data_in),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ack  (cmd_ack),
        .busy     (busy),
        .aborted  (aborted),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit          commit;
        logic [63:0] word;
        commit = 1'b0;
        word    = '0;
        if (!rst_n) begin
            m_open = 0; m_done = 0; m_valid = 0; m_over = 0; m_abort = 0;
            m_cmd  = '0;
            m_q.delete();
            return;
        end
        m_abort = 0;
        if (!m_open) begin
            if (cs) begin
                m_open = 1;
                m_done = 0;
                m_q.delete();
                if (en) m_q.push_back(data_in);
            end
        end else if (!m_done) begin
            if (!cs) begin
                m_open  = 0;
                m_abort = 1;
                m_q.delete();
            end else if (en) begin
                m_q.push_back(data_in);
                if (m_q.size() == CMD_BYTES) begin
                    m_done = 1;
                    commit = 1;
                    foreach (m_q[i]) word[63-8*i -: 8] = m_q[i];
                end
            end
        end else if (!cs) begin
            m_open = 0;
        end
        if (commit) begin
            if (!m_valid || cmd_ack) begin
                m_cmd   = word;
                m_valid = 1;
            end else begin
                m_over = 1;
            end
        end else if (cmd_ack) begin
            m_valid = 0;
        end
    endfunction

    task automatic step(input logic r, input logic c, input logic e, input logic a,
                        input logic [7:0] d);
        @(negedge clk);
        rst_n = r; cs = c; en = e; cmd_ack = a; data_in = d;
        @(posedge clk);
        model_step();
        #1;
        check("cmd",       cmd,       m_cmd);
        check("cmd_valid", cmd_valid, m_valid);
        check("busy",      busy,      m_open);
        check("aborted",   aborted,   m_abort);
        check("overrun",   overrun,   m_over);
    endtask

    // Full window command; byte 0 is driven on the first cycle (IDLE if cs was low).
    task automatic send_cmd(input logic [63:0] w, input int gap, input logic ack_last);
        for (int i = 0; i < CMD_BYTES; i++) begin
            step(1, 1, 1, ack_last && (i == CMD_BYTES - 1), w[63-8*i -: 8]);
            if (i < CMD_BYTES - 1) repeat (gap) step(1, 1, 0, 0, 8'h00);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] wa, wb;
        logic [63:0] s1;
        s1 = 64'hB700_0000_0000_1234;

        // reset state
        step(0, 0, 0, 0, 8'h00);
        check("rst_cmd", cmd, 64'h0);
        check("rst_valid", cmd_valid, 1'b0);
        step(1, 0, 0, 0, 8'h00);

        // 1: basic capture and ack
        send_cmd(s1, 0, 0);
        check("s1_cmd", cmd, s1);
        check("s1_valid", cmd_valid, 1'b1);
        check("s1_busy", busy, 1'b1);
        step(1, 1, 0, 1, 8'h00);
        check("s1_ack", cmd_valid, 1'b0);
        step(1, 0, 0, 0, 8'h00);

        // 2: abort after 5 bytes, then clean capture
        wa = rand64();
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, wa[63-8*i -: 8]);
        step(1, 0, 1, 0, 8'h5A);
        check("s2_abort", aborted, 1'b1);
        step(1, 0, 0, 0, 8'h00);
        check("s2_abort_pulse", aborted, 1'b0);
        check("s2_valid", cmd_valid, 1'b0);
        wb = rand64();
        send_cmd(wb, 0, 0);
        check("s2_cmd", cmd, wb);
        step(1, 0, 0, 1, 8'h00);

        // 3: overrun, then ack on the exact commit cycle
        step(0, 0, 0, 0, 8'h00);
        wa = rand64(); wb = rand64();
        send_cmd(wa, 0, 0);
        step(1, 0, 0, 0, 8'h00);
        send_cmd(wb, 0, 0);
        check("s3_keep", cmd, wa);
        check("s3_over", overrun, 1'b1);
        step(0, 0, 0, 0, 8'h00);
        send_cmd(wa, 0, 0);
        step(1, 0, 0, 0, 8'h00);
        send_cmd(wb, 1, 1);
        check("s3_ackcommit", cmd, wb);
        check("s3_valid", cmd_valid, 1'b1);
        check("s3_noover", overrun, 1'b0);

        // 4: strobes during RESP are ignored
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 8'hAA + 8'(i));
        check("s4_cmd", cmd, wb);

        // 5: reset mid-command while cmd_valid is high
        step(1, 0, 0, 0, 8'h00);
        wa = rand64();
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, wa[63-8*i -: 8]);
        step(0, 1, 1, 0, 8'hEE);
        check("s5_cmd", cmd, 64'h0);
        check("s5_flags", {cmd_valid, busy, aborted, overrun}, 4'h0);
        wb = rand64();
        send_cmd(wb, 0, 0);
        check("s5_recover", cmd, wb);

        // 6: sparse strobes
        step(1, 0, 0, 1, 8'h00);
        send_cmd(s1, 2, 0);
        check("s6_cmd", cmd, s1);
        step(1, 0, 0, 1, 8'h00);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, c, e, a;
            r = ($urandom_range(0, 299) != 0);
            c = ($urandom_range(0, 15) == 0) ? ~cs : cs;
            e = $urandom_range(0, 1) != 0;
            a = ($urandom_range(0, 3) == 0);
            step(r, c, e, a, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
